// File: rtl/uart_rx_8n1_if.sv
// rtl/uart_rx_8n1_if.sv - received-byte bundle from the 8-N-1 UART receiver
interface uart_rx_8n1_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  // Receiver drives the bundle
  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  // Downstream logic consumes the bundle
  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8-N-1 UART receiver with mid-bit sampling and framing check
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  uart_rx_8n1_if.master rx_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [2:0]    state;
  logic          ff1;
  logic          ff2;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          err_q;
  logic          rx_s;

  assign rx_s = ff2;

  // Two-flop synchroniser on the asynchronous line, idle-high after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ff1 <= 1'b1;
      ff2 <= 1'b1;
    end else begin
      ff1 <= rx;
      ff2 <= ff1;
    end
  end

  // Frame state machine: start qualification, data sampling, stop check
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      shreg   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            if (!rx_s) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= 3'd0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (rx_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              state   <= IDLE;
            end else begin
              err_q <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must not be mistaken for a new start bit
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_out.rx_data   = data_q;
  assign rx_out.rx_valid  = valid_q;
  assign rx_out.frame_err = err_q;
  assign rx_out.busy      = (state != IDLE);

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- 8-N-1 UART receiver; receive-side counterpart of the team's 8-bit UART transmitter.
- Synchronises the asynchronous serial input with a 2-FF chain (same technique as the button debouncer).
- Validates the start bit at mid-bit, samples 8 data bits LSB-first at bit centres, checks the stop bit.
- Delivers each byte on a one-cycle valid strobe to downstream logic (display/loopback to Tx).

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per bit period (100 MHz / 9600 baud); must be >= 4; testbench uses 16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous reset, active-low; sampled on rising clk edge.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  8  last correctly framed byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; rx_data=0x00; rx_valid=0; frame_err=0; busy=0.
  - Sync FFs=1; bit counter=0; bit index=0; shift register=0x00.
  - Overrides any frame in progress; a partial frame is discarded.
- Synchroniser: rx -> ff1 -> ff2 (rx_s); 2-cycle latency; only rx_s is used downstream.
- HALF = CLKS_PER_BIT/2 (integer division). Counter width = clog2(CLKS_PER_BIT).
- States:
  - IDLE:
    - rx_s==0 -> START, cnt=0.
    - Otherwise stay.
  - START:
    - cnt increments each cycle.
    - At cnt==HALF-1, sample rx_s:
      - 0 -> DATA, cnt=0, idx=0.
      - 1 -> IDLE (glitch rejected; no flags).
  - DATA:
    - cnt increments.
    - At cnt==CLKS_PER_BIT-1: shift rx_s into bit idx (LSB first), cnt=0, idx+1.
    - After idx==7 is sampled -> STOP.
  - STOP:
    - At cnt==CLKS_PER_BIT-1, sample rx_s:
      - 1 -> rx_data<=shift register, rx_valid=1 for one cycle, -> IDLE.
      - 0 -> frame_err=1 for one cycle, rx_data unchanged, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. This prevents a break/low line from being seen as a new start bit.
- Latency: with the first clk edge after rx falls numbered 1, the rx_valid/frame_err edge is 3 + HALF + 9*CLKS_PER_BIT (=155 for CLKS_PER_BIT=16).
- rx_valid and frame_err are mutually exclusive; neither is ever asserted 2 cycles in a row.
- Back-to-back frames: a new start bit is recognised the first cycle rx_s==0 in IDLE, i.e. immediately after a good stop sample. No idle gap is required.
- No flow control: rx_valid is not held. Downstream must capture rx_data in the pulse cycle, though rx_data remains stable until the next good frame.
- busy=1 from the edge entering START until the edge returning to IDLE.

Test Plan:
1. reset_n=0 for 3 cycles, rx=1 -> rx_data=0x00, rx_valid=0, frame_err=0, busy=0; stays so for 100 idle cycles after release.
2. CLKS_PER_BIT=16, send 0xA5 (8-N-1) -> rx_valid high exactly on edge 155 after rx falls, for 1 cycle; rx_data=0xA5; frame_err never high.
3. rx low for 4 cycles then high -> busy pulses, returns to IDLE by edge 11; no rx_valid/frame_err; rx_data unchanged.
4. Send 0x3C with stop bit driven 0 for 40 cycles, then high -> frame_err 1-cycle pulse on edge 155; no rx_valid; rx_data keeps prior value; busy stays 1 until 2 cycles after rx returns high.
5. Back-to-back 0x00 then 0xFF, single stop bit, no gap -> two rx_valid pulses 160 cycles apart; rx_data 0x00 then 0xFF.
6. Assert reset_n=0 mid-DATA of 0x55, release, then send 0xC3 -> no output from the aborted frame; single rx_valid with rx_data=0xC3.
